// File: rtl/obi_axil_bridge.sv
// OBI data-port to AXI4-Lite bridge: one outstanding transaction, registered
// completion pulse, and an optional watchdog that forces an error completion.
module obi_axil_bridge #(
  parameter logic [15:0] TimeoutCycles = 16'd1023
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [15:0] cnt_q, cnt_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        b_done_q, b_done_d;
  logic        b_err_q, b_err_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, timeout;

  // SLVERR and DECERR both carry resp[1]; written over the full code.
  function automatic logic resp_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

  assign data_gnt_o    = data_req_i && (state_q == IDLE);
  assign bready_o      = (state_q != READ);
  assign rready_o      = (state_q != WRITE);
  assign awvalid_o     = awvalid_q;
  assign wvalid_o      = wvalid_q;
  assign arvalid_o     = arvalid_q;
  assign awaddr_o      = addr_q & 32'hFFFF_FFFC;
  assign araddr_o      = addr_q & 32'hFFFF_FFFC;
  assign wdata_o       = wdata_q;
  assign wstrb_o       = be_q;
  assign data_rvalid_o = rsp_vld_q;
  assign data_err_o    = rsp_err_q;
  assign data_rdata_o  = rsp_rdata_q;

  assign aw_hs   = awvalid_q && awready_i;
  assign w_hs    = wvalid_q && wready_i;
  assign b_hs    = bvalid_i && bready_o;
  assign ar_hs   = arvalid_q && arready_i;
  assign r_hs    = rvalid_i && rready_o;
  assign timeout = (TimeoutCycles != 16'd0) && (cnt_q == TimeoutCycles - 16'd1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    b_done_d    = b_done_q;
    b_err_d     = b_err_q;
    rsp_vld_d   = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (data_req_i) begin
          addr_d    = data_addr_i;
          wdata_d   = data_wdata_i;
          be_d      = data_be_i;
          cnt_d     = 16'd0;
          awvalid_d = data_we_i;
          wvalid_d  = data_we_i;
          arvalid_d = !data_we_i;
          b_done_d  = 1'b0;
          b_err_d   = 1'b0;
          state_d   = data_we_i ? WRITE : READ;
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 16'd1;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs) wvalid_d = 1'b0;
        if (b_hs) begin
          b_done_d = 1'b1;
          b_err_d  = resp_err(bresp_i);
        end
        // A response may land before or alongside the address/data handshakes.
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs) && (b_done_q || b_hs)) begin
          state_d     = IDLE;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = b_hs ? resp_err(bresp_i) : b_err_q;
          rsp_rdata_d = 32'h0;
        end else if (timeout) begin
          state_d     = IDLE;
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end
      end
      READ: begin
        cnt_d = cnt_q + 16'd1;
        if (ar_hs) arvalid_d = 1'b0;
        if (r_hs) begin
          state_d     = IDLE;
          arvalid_d   = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = resp_err(rresp_i);
          rsp_rdata_d = rdata_i;
        end else if (timeout) begin
          state_d     = IDLE;
          arvalid_d   = 1'b0;
          rsp_vld_d   = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      cnt_q       <= 16'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      b_done_q    <= 1'b0;
      b_err_q     <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      b_done_q    <= b_done_d;
      b_err_q     <= b_err_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_obi_axil_bridge.sv
// Directed bench for obi_axil_bridge: each cycle drives inputs 1ns after the
// rising edge and checks outputs 2ns after it, against hand-derived values.
module tb_obi_axil_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = 32'h0;
  logic [31:0] data_wdata_i = 32'h0;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [31:0] awaddr_o;
  logic        wvalid_o;
  logic        wready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        bvalid_i = 1'b0;
  logic        bready_o;
  logic [1:0]  bresp_i = 2'b00;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [31:0] araddr_o;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic [31:0] rdata_i = 32'h0;
  logic [1:0]  rresp_i = 2'b00;

  int checks = 0;
  int failures = 0;

  obi_axil_bridge #(.TimeoutCycles(16'd8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_rvalid", 32'(data_rvalid_o), 0);
    chk("rst_err", 32'(data_err_o), 0);
    chk("rst_rdata", data_rdata_o, 32'h0);
    chk("rst_valids", {29'd0, awvalid_o, wvalid_o, arvalid_o}, 0);
    chk("rst_awaddr", awaddr_o, 32'h0);
    repeat (3) @(posedge clk_i);
    #3 rst_ni = 1'b1;

    // basic write, B one cycle after AW
    cyc(); data_req_i = 1; data_we_i = 1; data_be_i = 4'h1; data_addr_i = 32'h0;
    data_wdata_i = 32'h41; awready_i = 1; wready_i = 1; #1;
    chk("w1_gnt", 32'(data_gnt_o), 1);
    chk("w1_aw_c0", 32'(awvalid_o), 0);
    cyc(); data_req_i = 0; #1;
    chk("w1_aw_c1", 32'(awvalid_o), 1);
    chk("w1_w_c1", 32'(wvalid_o), 1);
    chk("w1_gnt_c1", 32'(data_gnt_o), 0);
    chk("w1_wdata", wdata_o, 32'h41);
    chk("w1_wstrb", 32'(wstrb_o), 32'h1);
    chk("w1_awaddr", awaddr_o, 32'h0);
    chk("w1_bready", 32'(bready_o), 1);
    cyc(); bvalid_i = 1; bresp_i = 2'b00; #1;
    chk("w1_aw_c2", 32'(awvalid_o), 0);
    chk("w1_w_c2", 32'(wvalid_o), 0);
    chk("w1_rv_c2", 32'(data_rvalid_o), 0);
    cyc(); bvalid_i = 0; #1;
    chk("w1_rv_c3", 32'(data_rvalid_o), 1);
    chk("w1_err", 32'(data_err_o), 0);
    chk("w1_rdata", data_rdata_o, 32'h0);
    cyc(); #1;
    chk("w1_rv_c4", 32'(data_rvalid_o), 0);

    // write with AW stalled 3 cycles, W immediate
    cyc(); data_req_i = 1; data_we_i = 1; data_be_i = 4'hF; data_addr_i = 32'h13;
    data_wdata_i = 32'hA5A5_5A5A; awready_i = 0; wready_i = 1; #1;
    chk("w2_gnt", 32'(data_gnt_o), 1);
    cyc(); data_req_i = 0; #1;
    chk("w2_aw_c1", 32'(awvalid_o), 1);
    chk("w2_w_c1", 32'(wvalid_o), 1);
    chk("w2_awaddr", awaddr_o, 32'h10);
    cyc(); #1;
    chk("w2_aw_c2", 32'(awvalid_o), 1);
    chk("w2_w_c2", 32'(wvalid_o), 0);
    cyc(); #1;
    chk("w2_aw_c3", 32'(awvalid_o), 1);
    chk("w2_w_c3", 32'(wvalid_o), 0);
    cyc(); awready_i = 1; #1;
    chk("w2_aw_c4", 32'(awvalid_o), 1);
    cyc(); bvalid_i = 1; bresp_i = 2'b00; #1;
    chk("w2_aw_c5", 32'(awvalid_o), 0);
    chk("w2_rv_c5", 32'(data_rvalid_o), 0);
    cyc(); bvalid_i = 0; #1;
    chk("w2_rv_c6", 32'(data_rvalid_o), 1);
    chk("w2_err", 32'(data_err_o), 0);
    cyc(); #1;
    chk("w2_rv_c7", 32'(data_rvalid_o), 0);

    // B coincides with AW/W handshakes, DECERR
    cyc(); data_req_i = 1; data_we_i = 1; data_addr_i = 32'h20; awready_i = 1; wready_i = 1; #1;
    cyc(); data_req_i = 0; bvalid_i = 1; bresp_i = 2'b11; #1;
    chk("w3_aw_c1", 32'(awvalid_o), 1);
    cyc(); bvalid_i = 0; bresp_i = 2'b00; #1;
    chk("w3_rv_c2", 32'(data_rvalid_o), 1);
    chk("w3_err", 32'(data_err_o), 1);
    chk("w3_aw_c2", 32'(awvalid_o), 0);

    // B arrives before AW handshake, SLVERR remembered
    cyc(); data_req_i = 1; data_we_i = 1; awready_i = 0; wready_i = 1; #1;
    chk("rv_after_w3", 32'(data_rvalid_o), 0);
    cyc(); data_req_i = 0; bvalid_i = 1; bresp_i = 2'b10; #1;
    cyc(); bvalid_i = 0; bresp_i = 2'b00; #1;
    chk("w4_rv_c2", 32'(data_rvalid_o), 0);
    cyc(); awready_i = 1; #1;
    chk("w4_rv_c3", 32'(data_rvalid_o), 0);
    chk("w4_aw_c3", 32'(awvalid_o), 1);
    cyc(); #1;
    chk("w4_rv_c4", 32'(data_rvalid_o), 1);
    chk("w4_err", 32'(data_err_o), 1);

    // read with SLVERR
    cyc(); data_req_i = 1; data_we_i = 0; data_addr_i = 32'h8; arready_i = 1; #1;
    chk("r1_gnt", 32'(data_gnt_o), 1);
    cyc(); data_req_i = 0; #1;
    chk("r1_ar_c1", 32'(arvalid_o), 1);
    chk("r1_araddr", araddr_o, 32'h8);
    chk("r1_rready", 32'(rready_o), 1);
    chk("r1_bready", 32'(bready_o), 0);
    cyc(); rvalid_i = 1; rresp_i = 2'b10; rdata_i = 32'hDEAD_BEEF; #1;
    chk("r1_ar_c2", 32'(arvalid_o), 0);
    cyc(); rvalid_i = 0; rresp_i = 2'b00; rdata_i = 32'h0; #1;
    chk("r1_rv_c3", 32'(data_rvalid_o), 1);
    chk("r1_err", 32'(data_err_o), 1);
    chk("r1_rdata", data_rdata_o, 32'hDEAD_BEEF);

    // read timeout, slave never responds (TimeoutCycles=8)
    cyc(); data_req_i = 1; data_we_i = 0; data_addr_i = 32'h8; arready_i = 0; #1;
    chk("to_gnt", 32'(data_gnt_o), 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(); data_req_i = 0; #1;
      chk("to_ar_held", 32'(arvalid_o), 1);
      chk("to_rv_low", 32'(data_rvalid_o), 0);
    end
    cyc(); #1;
    chk("to_rv_c9", 32'(data_rvalid_o), 1);
    chk("to_err", 32'(data_err_o), 1);
    chk("to_rdata", data_rdata_o, 32'h0);
    chk("to_ar_c9", 32'(arvalid_o), 0);
    cyc(); #1;
    chk("to_rv_c10", 32'(data_rvalid_o), 0);

    // stray B/R in IDLE are discarded
    cyc(); bvalid_i = 1; rvalid_i = 1; rdata_i = 32'h5; #1;
    chk("idle_bready", 32'(bready_o), 1);
    chk("idle_rready", 32'(rready_o), 1);
    cyc(); bvalid_i = 0; rvalid_i = 0; rdata_i = 32'h0; #1;
    chk("stray_rv1", 32'(data_rvalid_o), 0);
    cyc(); #1;
    chk("stray_rv2", 32'(data_rvalid_o), 0);

    // back-to-back reads with request held high
    cyc(); data_req_i = 1; data_we_i = 0; data_addr_i = 32'h4; arready_i = 1; #1;
    chk("bb_gnt0", 32'(data_gnt_o), 1);
    cyc(); #1;
    chk("bb_gnt_c1", 32'(data_gnt_o), 0);
    chk("bb_ar_c1", 32'(arvalid_o), 1);
    cyc(); rvalid_i = 1; rdata_i = 32'h1111_1111; #1;
    chk("bb_gnt_c2", 32'(data_gnt_o), 0);
    cyc(); rvalid_i = 0; rdata_i = 32'h0; #1;
    chk("bb_rv_c3", 32'(data_rvalid_o), 1);
    chk("bb_rdata1", data_rdata_o, 32'h1111_1111);
    chk("bb_gnt_c3", 32'(data_gnt_o), 1);
    cyc(); data_req_i = 0; #1;
    chk("bb_ar_c4", 32'(arvalid_o), 1);
    chk("bb_rv_c4", 32'(data_rvalid_o), 0);
    cyc(); rvalid_i = 1; rdata_i = 32'h2222_2222; #1;
    cyc(); rvalid_i = 0; rdata_i = 32'h0; #1;
    chk("bb_rv_c6", 32'(data_rvalid_o), 1);
    chk("bb_rdata2", data_rdata_o, 32'h2222_2222);

    // reset mid-write abandons the transaction
    cyc(); data_req_i = 1; data_we_i = 1; data_addr_i = 32'h30; awready_i = 0; wready_i = 0; #1;
    cyc(); data_req_i = 0; #1;
    chk("mr_aw_before", 32'(awvalid_o), 1);
    rst_ni = 1'b0; #1;
    chk("mr_aw_async", 32'(awvalid_o), 0);
    chk("mr_w_async", 32'(wvalid_o), 0);
    chk("mr_awaddr", awaddr_o, 32'h0);
    cyc(); cyc(); rst_ni = 1'b1;
    cyc(); bvalid_i = 1; #1;
    cyc(); bvalid_i = 0; #1;
    chk("mr_rv1", 32'(data_rvalid_o), 0);
    cyc(); #1;
    chk("mr_rv2", 32'(data_rvalid_o), 0);
    cyc(); data_req_i = 1; data_we_i = 0; data_addr_i = 32'h44; arready_i = 1; #1;
    chk("mr_gnt", 32'(data_gnt_o), 1);
    cyc(); data_req_i = 0; #1;
    chk("mr_araddr", araddr_o, 32'h44);
    cyc(); rvalid_i = 1; rdata_i = 32'h0BAD_F00D; rresp_i = 2'b00; #1;
    cyc(); rvalid_i = 0; rdata_i = 32'h0; #1;
    chk("mr_rv_done", 32'(data_rvalid_o), 1);
    chk("mr_rdata", data_rdata_o, 32'h0BAD_F00D);
    chk("mr_err", 32'(data_err_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
